ex_operand_stage: RTL and testbench

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

---
 rtl/ex_operand_stage.sv | 88 ++++++++
 tb/tb_ex_operand_stage.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ex_operand_stage: ID/EX pipeline register with EX-stage operand forwarding
// and load-use hazard detection for a 5-stage in-order pipeline.
module ex_operand_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rd1,
  input  logic [XLEN-1:0] id_rd2,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_alusrc,
  input  logic [2:0]      id_alucontrol,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic [4:0]      mem_rd,
  input  logic            mem_regwrite,
  input  logic [XLEN-1:0] mem_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_regwrite,
  input  logic [XLEN-1:0] wb_result,
  output logic            stall_id,
  output logic            ex_valid,
  output logic [XLEN-1:0] SrcA,
  output logic [XLEN-1:0] SrcB,
  output logic [2:0]      ALUControl,
  output logic [XLEN-1:0] ex_store_data,
  output logic [4:0]      ex_rd,
  output logic            ex_regwrite,
  output logic            ex_memread
);
  logic            valid_q, regwrite_q, memread_q, alusrc_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;
  logic [XLEN-1:0] rd1_q, rd2_q, imm_q;
  logic [2:0]      alu_q;
  logic            load_d;
  logic            mem_a, wb_a, mem_b, wb_b;
  // flush wins over stall: a killed instruction cannot cause a hazard
  assign stall_id = valid_q && memread_q && rd_q != 5'd0 && id_valid &&
                    (id_rs1 == rd_q || id_rs2 == rd_q) && !flush;
  assign load_d   = id_valid && !flush && !stall_id;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      alusrc_q   <= 1'b0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      rd1_q      <= '0;
      rd2_q      <= '0;
      imm_q      <= '0;
      alu_q      <= '0;
    end else begin
      valid_q    <= load_d;
      regwrite_q <= load_d && id_regwrite;
      memread_q  <= load_d && id_memread;
      if (load_d) begin
        rs1_q    <= id_rs1;
        rs2_q    <= id_rs2;
        rd_q     <= id_rd;
        rd1_q    <= id_rd1;
        rd2_q    <= id_rd2;
        imm_q    <= id_imm;
        alusrc_q <= id_alusrc;
        alu_q    <= id_alucontrol;
      end
    end
  end
  // x0 is hard-wired zero, so it never takes a forwarded value
  assign mem_a = mem_regwrite && mem_rd != 5'd0 && mem_rd == rs1_q;
  assign wb_a  = wb_regwrite  && wb_rd  != 5'd0 && wb_rd  == rs1_q;
  assign mem_b = mem_regwrite && mem_rd != 5'd0 && mem_rd == rs2_q;
  assign wb_b  = wb_regwrite  && wb_rd  != 5'd0 && wb_rd  == rs2_q;
  assign SrcA          = mem_a ? mem_result : wb_a ? wb_result : rd1_q;
  assign ex_store_data = mem_b ? mem_result : wb_b ? wb_result : rd2_q;
  assign SrcB          = alusrc_q ? imm_q : ex_store_data;
  assign ALUControl    = alu_q;
  assign ex_valid      = valid_q;
  assign ex_rd         = rd_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb_ex_operand_stage: directed and randomized checks of ex_operand_stage
// against a behavioural model of the instruction sitting in EX.
module tb_ex_operand_stage;
  localparam int XLEN = 32;
  logic clk = 1'b0, reset = 1'b1, flush = 1'b0, id_valid = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic [XLEN-1:0] id_rd1 = '0, id_rd2 = '0, id_imm = '0;
  logic id_alusrc = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
  logic [2:0] id_alucontrol = '0;
  logic [4:0] mem_rd = '0, wb_rd = '0;
  logic mem_regwrite = 1'b0, wb_regwrite = 1'b0;
  logic [XLEN-1:0] mem_result = '0, wb_result = '0;
  logic stall_id, ex_valid, ex_regwrite, ex_memread;
  logic [XLEN-1:0] SrcA, SrcB, ex_store_data;
  logic [2:0] ALUControl;
  logic [4:0] ex_rd;
  int errors = 0, checks = 0;
  typedef struct {
    logic valid, alusrc, rw, mr;
    logic [4:0] rs1, rs2, rd;
    logic [XLEN-1:0] rd1, rd2, imm;
    logic [2:0] alu;
  } instr_t;
  instr_t m;
  ex_operand_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .flush(flush), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_rd1(id_rd1), .id_rd2(id_rd2),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_alucontrol(id_alucontrol),
    .id_regwrite(id_regwrite), .id_memread(id_memread),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_result(mem_result),
    .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_result(wb_result),
    .stall_id(stall_id), .ex_valid(ex_valid), .SrcA(SrcA), .SrcB(SrcB),
    .ALUControl(ALUControl), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_memread(ex_memread)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [XLEN-1:0] operand(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (idx == 0) return rf;
    if (mem_regwrite && mem_rd == idx) return mem_result;
    if (wb_regwrite && wb_rd == idx) return wb_result;
    return rf;
  endfunction
  function automatic logic hazard();
    return m.valid && m.mr && m.rd != 0 && id_valid && !flush &&
           (id_rs1 == m.rd || id_rs2 == m.rd);
  endfunction
  task automatic model_reset();
    m = '{valid: 1'b0, alusrc: 1'b0, rw: 1'b0, mr: 1'b0, rs1: '0, rs2: '0, rd: '0,
          rd1: '0, rd2: '0, imm: '0, alu: '0};
  endtask
  task automatic step();
    logic enter;
    enter = id_valid && !flush && !hazard();
    @(posedge clk);
    m.valid = enter;
    if (enter) m = '{valid: 1'b1, alusrc: id_alusrc, rw: id_regwrite, mr: id_memread,
                     rs1: id_rs1, rs2: id_rs2, rd: id_rd, rd1: id_rd1, rd2: id_rd2,
                     imm: id_imm, alu: id_alucontrol};
    #1;
  endtask
  task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic [4:0] rd, input logic [XLEN-1:0] rd1, input logic [XLEN-1:0] rd2,
                          input logic [XLEN-1:0] imm, input logic alusrc, input logic [2:0] alu,
                          input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_rd1 = rd1; id_rd2 = rd2;
    id_imm = imm; id_alusrc = alusrc; id_alucontrol = alu; id_regwrite = rw; id_memread = mr;
  endtask
  task automatic producers(input logic mrw, input logic [4:0] mrd, input logic [XLEN-1:0] mres,
                           input logic wrw, input logic [4:0] wrd, input logic [XLEN-1:0] wres);
    mem_regwrite = mrw; mem_rd = mrd; mem_result = mres;
    wb_regwrite = wrw; wb_rd = wrd; wb_result = wres;
  endtask
  task automatic check_all();
    #1;
    check("stall_id", {31'd0, stall_id}, {31'd0, hazard()});
    check("ex_valid", {31'd0, ex_valid}, {31'd0, m.valid});
    check("ex_regwrite", {31'd0, ex_regwrite}, {31'd0, m.valid && m.rw});
    check("ex_memread", {31'd0, ex_memread}, {31'd0, m.valid && m.mr});
    if (m.valid) begin
      check("SrcA", SrcA, operand(m.rs1, m.rd1));
      check("store_data", ex_store_data, operand(m.rs2, m.rd2));
      check("SrcB", SrcB, m.alusrc ? m.imm : operand(m.rs2, m.rd2));
      check("ALUControl", {29'd0, ALUControl}, {29'd0, m.alu});
      check("ex_rd", {27'd0, ex_rd}, {27'd0, m.rd});
    end
  endtask
  initial begin
    model_reset();
    #12;
    check("rst_valid", {31'd0, ex_valid}, 32'd0);
    check("rst_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check("rst_alu", {29'd0, ALUControl}, 32'd0);
    @(negedge clk) reset = 1'b0;
    // first edge after reset captures normally
    drive_id(1, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 32'h33, 0, 3'd2, 1, 0);
    step();
    check("post_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("post_rst_rd", {27'd0, ex_rd}, 32'd3);
    // forwarding priority mem over wb, then wb alone
    drive_id(1, 5'd5, 5'd0, 5'd3, 32'h10, 32'h0, 32'h0, 0, 3'd1, 1, 0);
    producers(0, 0, 0, 0, 0, 0);
    step();
    producers(1, 5'd5, 32'h1234, 1, 5'd5, 32'h9999);
    #1 check("fwd_mem", SrcA, 32'h1234);
    mem_regwrite = 1'b0;
    #1 check("fwd_wb", SrcA, 32'h9999);
    // x0 never forwarded
    drive_id(1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 0, 3'd1, 1, 0);
    producers(0, 0, 0, 0, 0, 0);
    step();
    producers(1, 5'd0, 32'hFFFF, 0, 0, 0);
    #1 check("x0_srcA", SrcA, 32'h0);
    // immediate selected for B while store data still forwards
    drive_id(1, 5'd1, 5'd4, 5'd3, 32'h1, 32'h55, 32'hFFFF_FFFC, 1, 3'd0, 1, 0);
    producers(0, 0, 0, 0, 0, 0);
    step();
    producers(1, 5'd4, 32'hABCD, 0, 0, 0);
    #1 check("imm_srcB", SrcB, 32'hFFFF_FFFC);
    check("imm_store", ex_store_data, 32'hABCD);
    // load-use: one stall cycle then wb forwarding of the load result
    drive_id(1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h8, 1, 3'd0, 1, 1);
    producers(0, 0, 0, 0, 0, 0);
    step();
    drive_id(1, 5'd3, 5'd7, 5'd8, 32'h3, 32'h77, 32'h0, 0, 3'd4, 1, 0);
    #1 check("lu_stall", {31'd0, stall_id}, 32'd1);
    step();
    producers(1, 5'd7, 32'hDEAD, 0, 0, 0);
    #1 check("lu_bubble", {31'd0, ex_valid}, 32'd0);
    check("lu_release", {31'd0, stall_id}, 32'd0);
    step();
    producers(0, 0, 0, 1, 5'd7, 32'hCAFE);
    #1 check("lu_dep_valid", {31'd0, ex_valid}, 32'd1);
    check("lu_dep_srcB", SrcB, 32'hCAFE);
    // flush beats stall
    drive_id(1, 5'd1, 5'd2, 5'd7, 32'h0, 32'h0, 32'h8, 1, 3'd0, 1, 1);
    producers(0, 0, 0, 0, 0, 0);
    step();
    drive_id(1, 5'd7, 5'd0, 5'd8, 32'h3, 32'h0, 32'h0, 0, 3'd4, 1, 0);
    flush = 1'b1;
    #1 check("flush_stall", {31'd0, stall_id}, 32'd0);
    step();
    check("flush_bubble", {31'd0, ex_valid}, 32'd0);
    check("flush_regwrite", {31'd0, ex_regwrite}, 32'd0);
    flush = 1'b0;
    // asynchronous reset mid-cycle
    drive_id(1, 5'd1, 5'd2, 5'd9, 32'h0, 32'h0, 32'h0, 0, 3'd5, 1, 0);
    step();
    check("pre_rst_valid", {31'd0, ex_valid}, 32'd1);
    check("pre_rst_rw", {31'd0, ex_regwrite}, 32'd1);
    #2 reset = 1'b1;
    #1 check("arst_valid", {31'd0, ex_valid}, 32'd0);
    check("arst_regwrite", {31'd0, ex_regwrite}, 32'd0);
    check("arst_rd", {27'd0, ex_rd}, 32'd0);
    check("arst_alu", {29'd0, ALUControl}, 32'd0);
    model_reset();
    @(negedge clk) reset = 1'b0;
    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive_id($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 1'($urandom),
               3'($urandom), 1'($urandom), $urandom_range(0, 2) == 0);
      producers(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                1'($urandom), 5'($urandom_range(0, 7)), $urandom);
      flush = $urandom_range(0, 7) == 0;
      check_all();
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
